// File: rtl/lsu_apb.sv
// lsu_apb: single-outstanding load/store unit for the 32-bit RISC-V core.
// Each request is performed as one APB4 master transfer. Load results are
// aligned and extended, then presented for one cycle on the register-file
// write port. Misaligned or illegal requests skip the bus and only flag err.
module lsu_apb (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WB} state_t;

    state_t      state_q, state_d;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        err_q;
    logic [31:0] data_q;
    logic        accept;
    logic        req_bad;
    logic        xfer_done;

    // Illegal encodings and misaligned halfword/word addresses.
    function automatic logic is_bad(input logic store, input logic [2:0] f3,
                                    input logic [1:0] off);
        logic illegal;
        logic misaligned;
        illegal    = (store && f3[2]) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return illegal || misaligned;
    endfunction

    // Replicate store data across every lane it may land in.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Byte strobes for the addressed lane(s).
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Shift the addressed lane down, then sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic        [31:0] lane;
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        lane = rdata >> {off, 3'b000};
        b8   = lane[7:0];
        h16  = lane[15:0];
        case (f3)
            3'b000:  return 32'(b8);
            3'b001:  return 32'(h16);
            3'b100:  return {24'd0, lane[7:0]};
            3'b101:  return {16'd0, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    assign accept    = (state_q == IDLE) && req_valid;
    assign req_bad   = is_bad(req_store, req_funct3, req_addr[1:0]);
    assign xfer_done = (state_q == ACCESS) && pready;

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Error flag: set on a bad request at accept, or by pslverr at transfer end.
    always_ff @(posedge clk) begin
        if (reset)          err_q <= 1'b0;
        else if (accept)    err_q <= req_bad;
        else if (xfer_done) err_q <= pslverr;
    end

    // Request latch; data only, qualified by the state for every output use.
    always_ff @(posedge clk) begin
        if (accept) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
        end
    end

    // Load result capture on the completing ACCESS edge.
    always_ff @(posedge clk) begin
        if (xfer_done) data_q <= load_extend(funct3_q, addr_q[1:0], prdata);
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = 32'd0;
        pwdata    = 32'd0;
        pstrb     = 4'd0;
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_d = req_bad ? WB : SETUP;
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) state_d = WB;
            end
            WB: begin
                wb_we   = !store_q && !err_q && (rd_q != 5'd0);
                wb_rd   = rd_q;
                wb_data = wb_we ? data_q : 32'd0;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (psel) begin
            pwrite = store_q;
            paddr  = {addr_q[31:2], 2'b00};
            if (store_q) begin
                pwdata = store_data(funct3_q, wdata_q);
                pstrb  = store_strb(funct3_q, addr_q[1:0]);
            end
        end
    end

endmodule
